// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared core definitions for the femtoRV32 front end:
//                datapath width, instruction-memory geometry, the bubble
//                instruction and the IF/ID bundle consumed by decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  // Architectural datapath width.
  localparam int unsigned XLEN = 32;

  // Instruction memory is 64 words, addressed by word.
  localparam int unsigned CORE_IMEM_AW = 6;

  // addi x0,x0,0 - what decode sees when IF/ID holds a bubble.
  localparam logic [XLEN-1:0] CORE_NOP_INST = 32'h0000_0013;

  // Default boot address.
  localparam logic [XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;

  // IF/ID pipeline bundle, shared with the decode stage.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  // A byte target is misaligned for 32-bit instructions when its low
  // two bits are not zero.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
// ============================================================================
//  Module      : fetch_stage_pc_reg
//  Description : Program counter for the fetch stage. Applies the
//                reset > redirect > stall > increment priority and tells
//                the stage when a normal fetch cycle is taking place.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_redirect_en,
  // Word part of the redirect target; the byte offset is dropped here
  // because the PC is always kept word aligned.
  input  logic [XLEN-3:0] i_redirect_word,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_advance
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_advance;

  // Next-PC selection: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    w_pc_next = r_pc;
    w_advance = 1'b0;
    if (i_redirect_en) begin
      w_pc_next = {i_redirect_word, 2'b00};
    end else if (!i_stall) begin
      // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
      w_pc_next = r_pc + 32'd4;
      w_advance = 1'b1;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc      = r_pc;
  assign o_pc_next = w_pc_next;
  assign o_advance = w_advance;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : femtoRV32 instruction-fetch stage. Drives the word address
//                into the asynchronous-read instruction memory, captures the
//                returned word into IF/ID, inserts bubbles on redirect,
//                flags misaligned redirect targets and counts fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC,
  parameter int              IMEM_AW  = CORE_IMEM_AW,
  parameter logic [XLEN-1:0] NOP_INST = CORE_NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [XLEN-1:0]    redirect_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  output logic [XLEN-1:0]    if_id_pc,
  output logic [XLEN-1:0]    if_id_pc_plus4,
  output logic [XLEN-1:0]    if_id_inst,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [XLEN-1:0]    fetch_count
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_advance;
  logic            w_target_misaligned;

  if_id_t          r_if_id;
  logic            r_misalign_err;
  logic [XLEN-1:0] r_fetch_count;

  fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_redirect_en   (redirect_en),
    .i_redirect_word (redirect_target[XLEN-1:2]),
    .o_pc            (w_pc),
    .o_pc_next       (w_pc_next),
    .o_advance       (w_advance)
  );

  assign w_target_misaligned = is_misaligned(redirect_target[1:0]);

  // IF/ID register: bubble on reset or redirect, hold on stall, otherwise
  // capture the word the memory is returning for the current PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (redirect_en) begin
      // The flushed slot keeps its old pc; only inst/valid are cleared.
      r_if_id.inst  <= NOP_INST;
      r_if_id.valid <= 1'b0;
    end else if (w_advance) begin
      r_if_id.pc    <= w_pc;
      r_if_id.inst  <= imem_data;
      r_if_id.valid <= 1'b1;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (redirect_en && w_target_misaligned) begin
      r_misalign_err <= 1'b1;
    end
  end

  // Count of real instructions loaded into IF/ID (wraps at 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_advance) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Only the word index inside the 64-word memory is driven; upper PC
  // bits alias silently.
  assign imem_addr      = w_pc[IMEM_AW+1:2];

  assign if_id_pc       = r_if_id.pc;
  assign if_id_pc_plus4 = r_if_id.pc + 32'd4;
  assign if_id_inst     = r_if_id.inst;
  assign if_id_valid    = r_if_id.valid;
  assign misalign_err   = r_misalign_err;
  assign fetch_count    = r_fetch_count;

  // The next-PC value is exported by the PC register for later stages
  // (e.g. a branch predictor); the fetch datapath itself does not need it.
  logic w_unused;
  assign w_unused = ^w_pc_next;

endmodule

`default_nettype wire
